demux_dispatch: RTL and testbench

DEMUX_DISPATCH -- requirements
Module: demux_dispatch

---
 rtl/demux_dispatch_if.sv | 35 +++
 rtl/demux_dispatch.sv | 73 +++++++
 tb/tb_demux_dispatch.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/demux_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_dispatch_if
// Description : Handshake bundle between an upstream source, the dispatcher
//               and N = 2**S downstream lanes.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_dispatch_if #(
   parameter int S = 3,
   parameter int T = 1
);
   localparam int N = 2**S;

   logic             in_valid;
   logic             in_ready;
   logic [T-1:0]     in_data;
   logic [S-1:0]     in_dest;
   logic             rr_en;
   logic [N-1:0]     out_valid;
   logic [N-1:0]     out_ready;
   logic [N*T-1:0]   out_data;

   // Dispatcher side.
   modport slave (
      input  in_valid, in_data, in_dest, rr_en, out_ready,
      output in_ready, out_valid, out_data
   );

   // Source/sink side.
   modport master (
      output in_valid, in_data, in_dest, rr_en, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface
`default_nettype wire

// File: rtl/demux_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : demux_dispatch
// Description : One-word register slice that steers each word to a single
//               output lane chosen by in_dest or by a round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_dispatch #(
   parameter int S = 3,
   parameter int T = 1
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   demux_dispatch_if.slave   bus
);
   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [T-1:0]   held_data;
   logic [S-1:0]   held_dest;
   logic [S-1:0]   rr_ptr;
   logic           held_ready;
   logic           in_fire;

   assign held_ready = bus.out_ready[held_dest];
   assign in_fire    = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         held_data <= '0;
         held_dest <= '0;
         rr_ptr    <= '0;
      end else begin
         state <= state_nxt;
         if (in_fire) begin
            held_data <= bus.in_data;
            held_dest <= bus.rr_en ? rr_ptr : bus.in_dest;
            if (bus.rr_en) begin
               rr_ptr <= rr_ptr + S'(1);
            end
         end
      end
   end

   // in_ready depends only on state and the held lane's ready, never on in_valid.
   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b1;
      bus.out_valid = '0;
      bus.out_data  = '0;
      case (state)
         EMPTY: begin
            if (bus.in_valid) begin
               state_nxt = FULL;
            end
         end
         FULL: begin
            bus.in_ready                         = held_ready;
            bus.out_valid[held_dest]             = 1'b1;
            bus.out_data[int'(held_dest)*T +: T] = held_data;
            if (held_ready && !bus.in_valid) begin
               state_nxt = EMPTY;
            end
         end
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_demux_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_dispatch
// Description : Directed scoreboard bench for demux_dispatch (S=3, T=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_dispatch;
   localparam int S = 3;
   localparam int T = 4;
   localparam int N = 2**S;

   typedef struct packed {
      logic [S-1:0] dest;
      logic [T-1:0] data;
   } word_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   word_t        sb[$];
   word_t        seen[$];
   logic [S-1:0] m_ptr = '0;

   demux_dispatch_if #(.S(S), .T(T)) bus ();

   demux_dispatch #(.S(S), .T(T)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model evaluated mid-cycle while inputs are stable.
   always @(negedge clk) begin
      logic [N-1:0]   exp_v;
      logic [N*T-1:0] exp_d;
      logic           exp_rdy;
      word_t          w;
      if (!rst_n) begin
         sb.delete();
         m_ptr = '0;
      end else begin
         exp_v   = '0;
         exp_d   = '0;
         exp_rdy = 1'b1;
         if (sb.size() != 0) begin
            exp_v   = N'(1) << sb[0].dest;
            exp_d   = (N*T)'(sb[0].data) << (int'(sb[0].dest) * T);
            exp_rdy = bus.out_ready[sb[0].dest];
         end
         chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
         chk("out_data", 64'(bus.out_data), 64'(exp_d));
         chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
         chk("onehot", 64'($countones(bus.out_valid) <= 1), 64'(1));
         for (int k = 0; k < N; k++) begin
            if (bus.out_valid[k] && bus.out_ready[k]) begin
               w.dest = S'(k);
               w.data = bus.out_data[k*T +: T];
               seen.push_back(w);
            end
         end
         if (sb.size() != 0 && exp_rdy) begin
            void'(sb.pop_front());
         end
         if (bus.in_valid && exp_rdy) begin
            w.dest = bus.rr_en ? m_ptr : bus.in_dest;
            w.data = bus.in_data;
            sb.push_back(w);
            if (bus.rr_en) m_ptr = m_ptr + 3'd1;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [T-1:0] d, input logic [S-1:0] dst, input logic rr);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_dest  = dst;
      bus.rr_en    = rr;
   endtask

   task automatic chk_seen(input string tag, input int idx, input int dst, input int dat);
      if (idx < seen.size()) begin
         chk({tag, "_dest"}, 64'(seen[idx].dest), 64'(dst));
         chk({tag, "_data"}, 64'(seen[idx].data), 64'(dat));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int e036[5];
      e036 = '{0, 1, 2, 6, 3};
      rst_n         = 1'b0;
      bus.out_ready = '1;
      drive(1'b0, '0, '0, 1'b0);
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_out_data", 64'(bus.out_data), 64'(0));
      cyc(); cyc();
      rst_n = 1'b1;

      // Single word to lane 5.
      drive(1'b1, 4'hA, 3'd5, 1'b0);
      cyc();
      drive(1'b0, '0, '0, 1'b0);
      @(negedge clk);
      chk("w5_valid", 64'(bus.out_valid), 64'h20);
      chk("w5_data", 64'(bus.out_data), 64'h00A0_0000);
      cyc();
      @(negedge clk);
      chk("w5_empty", 64'(bus.out_valid), 64'h0);

      // Backpressure on lane 5; ready on other lanes must not matter.
      cyc();
      seen.delete();
      bus.out_ready = 8'hDF;
      drive(1'b1, 4'h3, 3'd5, 1'b0);
      cyc();
      drive(1'b1, 4'h9, 3'd1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
         chk("bp_data", 64'(bus.out_data), 64'h0030_0000);
         cyc();
      end
      drive(1'b0, '0, '0, 1'b0);
      bus.out_ready = '1;
      @(negedge clk);
      chk("bp_release_ready", 64'(bus.in_ready), 64'(1));
      cyc(); cyc();
      chk("bp_count", 64'(seen.size()), 64'(1));
      chk_seen("bp", 0, 5, 3);

      // Streaming, one word per cycle.
      seen.delete();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4'(i), 3'(7 - i), 1'b0);
         cyc();
      end
      drive(1'b0, '0, '0, 1'b0);
      cyc(); cyc();
      chk("stream_count", 64'(seen.size()), 64'(8));
      for (int i = 0; i < 8; i++) chk_seen("stream", i, 7 - i, i);

      // Round-robin with a stall after the 4th word.
      seen.delete();
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            drive(1'b0, 4'hF, 3'd0, 1'b1);
            cyc();
         end
         drive(1'b1, 4'(i), 3'd0, 1'b1);
         cyc();
      end
      drive(1'b0, '0, '0, 1'b0);
      cyc(); cyc();
      chk("rr_count", 64'(seen.size()), 64'(10));
      for (int i = 0; i < 10; i++) chk_seen("rr", i, i % 8, i);

      // Asynchronous reset while holding a word for lane 2.
      drive(1'b1, 4'h7, 3'd2, 1'b0);
      bus.out_ready = 8'h00;
      cyc();
      drive(1'b0, '0, '0, 1'b0);
      #2;
      chk("pre_rst_valid", 64'(bus.out_valid), 64'h04);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(bus.out_valid), 64'h0);
      chk("async_rst_data", 64'(bus.out_data), 64'h0);
      chk("async_rst_ready", 64'(bus.in_ready), 64'(1));
      cyc();
      bus.out_ready = '1;
      rst_n = 1'b1;
      seen.delete();

      // Mixed round-robin and direct, first word on the first edge after release.
      for (int i = 0; i < 5; i++) begin
         if (i == 3) drive(1'b1, 4'(i + 1), 3'd6, 1'b0);
         else        drive(1'b1, 4'(i + 1), 3'd0, 1'b1);
         cyc();
      end
      drive(1'b0, '0, '0, 1'b0);
      cyc(); cyc();
      chk("mix_count", 64'(seen.size()), 64'(5));
      for (int i = 0; i < 5; i++) chk_seen("mix", i, e036[i], i + 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
